player_ctrl: RTL and testbench

- Parametrised successor to the single-step hero controller for the tile-map game.
- Turns low-active direction buttons into grid moves, with edge detection, hold-to-repeat and a one-deep pending-press buffer.
- Fetches the target tile over a req/valid handshake with the map RAM, bounds-checks the move and classifies the tile as floor, wall or interactive.
- Drives hero position, facing direction, appearance and an interaction event toward the render and game-logic blocks.

---
 rtl/player_pkg.sv | 26 ++
 rtl/player_ctrl_if.sv | 17 +
 rtl/player_ctrl_btn_repeat.sv | 74 +++++++
 rtl/player_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_player_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the hero controller: direction codes, FSM state
// encodings and the tile/sprite ids the controller recognises.
package player_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_U = 2'd1,
    DIR_D = 2'd2,
    DIR_L = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESOLVE = 2'd3
  } state_e;

  // Tile ids returned by the map RAM
  localparam logic [15:0] TILE_FLOOR   = 16'h0000;
  localparam logic [15:0] TILE_WALL    = 16'h0001;

  // First hero sprite in the resource table
  localparam logic [15:0] RS_HERO_BASE = 16'h0100;

endpackage

// File: rtl/player_ctrl_if.sv
// Map RAM request/response channel: the controller asks for one tile and
// the RAM answers with a tile_vld strobe.
interface player_ctrl_if #(
  parameter int COORD_W = 4,
  parameter int TILE_W  = 16
) ();
  logic               tile_req;
  logic [COORD_W-1:0] goto_pos_x;
  logic [COORD_W-1:0] goto_pos_y;
  logic               tile_vld;
  logic [TILE_W-1:0]  goto_tile_id;

  modport master (output tile_req, goto_pos_x, goto_pos_y,
                  input  tile_vld, goto_tile_id);
  modport slave  (input  tile_req, goto_pos_x, goto_pos_y,
                  output tile_vld, goto_tile_id);
endinterface

// File: rtl/player_ctrl_btn_repeat.sv
// Button front end: registers the low-active buttons, picks the
// highest-priority direction (R > U > D > L) and emits one-cycle move
// events on a new press and on hold-to-repeat.
module btn_repeat
  import player_pkg::*;
#(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] btn_i,
  output logic       evt_o,
  output dir_e       dir_o
);

  localparam int CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1) + 1;

  logic [3:0]    btn_q;
  logic          act, act_q, rep_q, rep_d;
  dir_e          dir, dir_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press, rpt;

  // Priority resolve on the registered buttons
  always_comb begin
    act = ~&btn_q;
    dir = DIR_L;
    if (!btn_q[3])      dir = DIR_R;
    else if (!btn_q[2]) dir = DIR_U;
    else if (!btn_q[1]) dir = DIR_D;
  end

  // Press / repeat detection; the counter holds cycles since the last event
  always_comb begin
    press = act && (!act_q || (dir != dir_q));
    rpt   = act && !press &&
            (cnt_q == (rep_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DLY)));
    cnt_d = cnt_q + 1'b1;
    rep_d = rep_q;
    if (!act) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (press) begin
      cnt_d = CW'(1);
      rep_d = 1'b0;
    end else if (rpt) begin
      cnt_d = CW'(1);
      rep_d = 1'b1;
    end
  end

  // Input register and hold-tracking state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_q <= 4'hF;
      act_q <= 1'b0;
      dir_q <= DIR_R;
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      act_q <= act;
      dir_q <= dir;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

  assign evt_o = press || rpt;
  assign dir_o = dir;

endmodule

// File: rtl/player_ctrl.sv
// Hero controller: turns button events into bounds-checked grid moves,
// fetches the target tile from the map RAM and resolves floor / wall /
// interactive tiles. Optional walk-frame sprite toggle: PLAYER_WALK_ANIM_EN.
module player_ctrl
  import player_pkg::*;
#(
  parameter int COORD_W      = 4,
  parameter int MAP_W        = 13,
  parameter int MAP_H        = 13,
  parameter int START_X      = 6,
  parameter int START_Y      = 11,
  parameter int TILE_W       = 16,
  parameter int REPEAT_DLY   = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [3:0]         btn,
  input  logic               lock,
  player_ctrl_if.master      ram,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         facing,
  output logic               busy,
  output logic               evt_vld,
  output logic [TILE_W-1:0]  evt_tile_id,
  output logic [TILE_W-1:0]  appearance
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

  state_e             state_q, state_d;
  dir_e               facing_q, evt_dir, go_dir, pend_dir_q, pend_dir_d;
  logic               evt, go, oob, oob_q, pend_vld_q, pend_vld_d;
  logic [COORD_W-1:0] pos_x_q, pos_y_q, goto_x_q, goto_y_q, tgt_x, tgt_y;
  logic [WCW-1:0]     wcnt_q;
  logic [TILE_W-1:0]  tile_q, evt_id_q;
  logic               evt_vld_q, move;

  btn_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_btn (
    .clk   (clk),
    .rstn  (rstn),
    .btn_i (btn),
    .evt_o (evt),
    .dir_o (evt_dir)
  );

  // Event selection for IDLE: a buffered press beats a same-cycle new one
  always_comb begin
    go     = 1'b0;
    go_dir = evt_dir;
    if (!lock) begin
      if (pend_vld_q) begin
        go     = 1'b1;
        go_dir = pend_dir_q;
      end else if (evt) begin
        go = 1'b1;
      end
    end
  end

  // Target tile and edge check; an off-map target keeps goto on pos
  always_comb begin
    oob   = 1'b0;
    tgt_x = pos_x_q;
    tgt_y = pos_y_q;
    case (go_dir)
      DIR_R: begin oob = (pos_x_q == COORD_W'(MAP_W - 1)); tgt_x = pos_x_q + COORD_W'(1); end
      DIR_L: begin oob = (pos_x_q == '0);                  tgt_x = pos_x_q - COORD_W'(1); end
      DIR_U: begin oob = (pos_y_q == '0);                  tgt_y = pos_y_q - COORD_W'(1); end
      DIR_D: begin oob = (pos_y_q == COORD_W'(MAP_H - 1)); tgt_y = pos_y_q + COORD_W'(1); end
    endcase
    if (oob) begin
      tgt_x = pos_x_q;
      tgt_y = pos_y_q;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go) state_d = ST_CHECK;
      ST_CHECK:   state_d = oob_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:    if (ram.tile_vld)                          state_d = ST_RESOLVE;
                  else if (wcnt_q == WCW'(WAIT_TIMEOUT - 1)) state_d = ST_IDLE;
      ST_RESOLVE: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Pending buffer: holds the newest press seen while busy, lock flushes it
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    if (lock || state_q == ST_IDLE) begin
      pend_vld_d = 1'b0;
    end else if (evt) begin
      pend_vld_d = 1'b1;
      pend_dir_d = evt_dir;
    end
  end

  // Pending buffer register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_R;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign move = (state_q == ST_RESOLVE) && (tile_q == TILE_W'(TILE_FLOOR));

  // Datapath: latch move, capture tile, commit position or raise event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      facing_q  <= DIR_D;
      pos_x_q   <= COORD_W'(START_X);
      pos_y_q   <= COORD_W'(START_Y);
      goto_x_q  <= COORD_W'(START_X);
      goto_y_q  <= COORD_W'(START_Y);
      oob_q     <= 1'b0;
      wcnt_q    <= '0;
      tile_q    <= '0;
      evt_vld_q <= 1'b0;
      evt_id_q  <= '0;
    end else begin
      evt_vld_q <= 1'b0;
      wcnt_q    <= (state_q == ST_WAIT) ? wcnt_q + 1'b1 : '0;
      case (state_q)
        ST_IDLE: if (go) begin
          facing_q <= go_dir;
          goto_x_q <= tgt_x;
          goto_y_q <= tgt_y;
          oob_q    <= oob;
        end
        ST_WAIT: if (ram.tile_vld) tile_q <= ram.goto_tile_id;
        ST_RESOLVE: begin
          if (move) begin
            pos_x_q <= goto_x_q;
            pos_y_q <= goto_y_q;
          end else if (tile_q != TILE_W'(TILE_WALL)) begin
            evt_vld_q <= 1'b1;
            evt_id_q  <= tile_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PLAYER_WALK_ANIM_EN
  logic frame_q;

  // Walk frame flips on every committed step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     frame_q <= 1'b0;
    else if (move) frame_q <= ~frame_q;
  end

  assign appearance = TILE_W'(RS_HERO_BASE) + TILE_W'({facing_q, frame_q});
`else
  assign appearance = TILE_W'(RS_HERO_BASE) + TILE_W'(facing_q);
`endif

  assign ram.tile_req   = (state_q == ST_CHECK) && !oob_q;
  assign ram.goto_pos_x = goto_x_q;
  assign ram.goto_pos_y = goto_y_q;
  assign pos_x          = pos_x_q;
  assign pos_y          = pos_y_q;
  assign facing         = facing_q;
  assign busy           = (state_q != ST_IDLE);
  assign evt_vld        = evt_vld_q;
  assign evt_tile_id    = evt_id_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: table of single taps plus hand-written
// sequences for latency, auto-repeat, pending buffer, lock, timeout, reset.
module tb_player_ctrl;
  import player_pkg::*;

`ifdef PLAYER_WALK_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  btn = 4'hF;
  logic        lock = 1'b0;
  logic [3:0]  pos_x, pos_y;
  logic [1:0]  facing;
  logic        busy, evt_vld;
  logic [15:0] evt_tile_id, appearance;

  logic        resp_en = 1'b1;
  logic        stray = 1'b0;
  logic [15:0] resp_id = TILE_FLOOR;
  int          req_cnt = 0, evt_cnt = 0;
  logic [15:0] last_id = '0;
  logic        fr_m = 1'b0;
  int          pass = 0, total = 0;

  player_ctrl_if #(.COORD_W(4), .TILE_W(16)) ram ();

  player_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn         (btn),
    .lock        (lock),
    .ram         (ram),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing      (facing),
    .busy        (busy),
    .evt_vld     (evt_vld),
    .evt_tile_id (evt_tile_id),
    .appearance  (appearance)
  );

  always #5 clk = ~clk;

  // Map RAM model: answers one cycle after the request
  always @(posedge clk) begin
    ram.tile_vld     <= (ram.tile_req && resp_en) || stray;
    ram.goto_tile_id <= resp_id;
  end

  // Count request and event cycles
  always @(negedge clk) begin
    if (ram.tile_req === 1'b1) req_cnt <= req_cnt + 1;
    if (evt_vld === 1'b1) begin
      evt_cnt <= evt_cnt + 1;
      last_id <= evt_tile_id;
    end
  end

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] tile;
    logic [3:0]  ex, ey;
    logic [1:0]  ef;
    int          dreq, devt;
  } vec_t;

  vec_t tbl[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_app(input logic [1:0] f);
    return ANIM ? RS_HERO_BASE + {13'd0, f, fr_m} : RS_HERO_BASE + {14'd0, f};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    fr_m = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_px"},   pos_x, 6);
    chk({tag, "_py"},   pos_y, 11);
    chk({tag, "_gx"},   ram.goto_pos_x, 6);
    chk({tag, "_gy"},   ram.goto_pos_y, 11);
    chk({tag, "_face"}, facing, 2);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"},  ram.tile_req, 0);
    chk({tag, "_evt"},  evt_vld, 0);
    chk({tag, "_eid"},  evt_tile_id, 0);
    chk({tag, "_app"},  appearance, exp_app(2'd2));
  endtask

  initial begin
    int r0, e0;
    logic [3:0] px, py;

    tbl[0] = '{4'b0111, TILE_FLOOR, 4'd7, 4'd11, 2'd0, 1, 0};
    tbl[1] = '{4'b1110, TILE_FLOOR, 4'd6, 4'd11, 2'd3, 1, 0};
    tbl[2] = '{4'b1011, TILE_WALL,  4'd6, 4'd11, 2'd1, 1, 0};
    tbl[3] = '{4'b1011, 16'h0042,   4'd6, 4'd11, 2'd1, 1, 1};
    tbl[4] = '{4'b1101, TILE_FLOOR, 4'd6, 4'd12, 2'd2, 1, 0};
    tbl[5] = '{4'b1101, TILE_FLOOR, 4'd6, 4'd12, 2'd2, 0, 0};
    tbl[6] = '{4'b0011, TILE_FLOOR, 4'd7, 4'd12, 2'd0, 1, 0};
    tbl[7] = '{4'b1000, TILE_FLOOR, 4'd7, 4'd11, 2'd1, 1, 0};
    tbl[8] = '{4'b1100, TILE_FLOOR, 4'd7, 4'd12, 2'd2, 1, 0};
    tbl[9] = '{4'b1110, TILE_FLOOR, 4'd6, 4'd12, 2'd3, 1, 0};

    // Reset values
    tick(2);
    chk_reset_state("rst");
    rstn = 1'b1;
    tick(1);

    // Tap R onto floor: request and commit timing
    btn = 4'b0111;
    tick(1);
    btn = 4'hF;
    chk("lat_busy0", busy, 0);
    tick(1);
    chk("lat_req", ram.tile_req, 1);
    chk("lat_gx", ram.goto_pos_x, 7);
    tick(1);
    chk("lat_gy_wait", ram.goto_pos_y, 11);
    tick(1);
    chk("lat_px_before", pos_x, 6);
    tick(1);
    chk("lat_px_after", pos_x, 7);
    chk("lat_face", facing, 0);
    chk("lat_evt", evt_cnt, 0);
    chk("lat_busy1", busy, 0);

    // Table of single taps from (6,11)
    do_reset();
    px = 4'd6;
    py = 4'd11;
    for (int i = 0; i < 10; i++) begin
      resp_id = tbl[i].tile;
      r0 = req_cnt;
      e0 = evt_cnt;
      btn = tbl[i].btn;
      tick(1);
      btn = 4'hF;
      tick(10);
      if (tbl[i].ex != px || tbl[i].ey != py) fr_m = ~fr_m;
      px = tbl[i].ex;
      py = tbl[i].ey;
      chk($sformatf("v%0d_px", i),   pos_x, tbl[i].ex);
      chk($sformatf("v%0d_py", i),   pos_y, tbl[i].ey);
      chk($sformatf("v%0d_face", i), facing, tbl[i].ef);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_req", i),  req_cnt - r0, tbl[i].dreq);
      chk($sformatf("v%0d_evt", i),  evt_cnt - e0, tbl[i].devt);
      chk($sformatf("v%0d_app", i),  appearance, exp_app(tbl[i].ef));
      if (tbl[i].devt != 0) chk($sformatf("v%0d_eid", i), last_id, tbl[i].tile);
    end
    resp_id = TILE_FLOOR;

    // Hold L for 30 cycles: press, then repeats, stopping at x=0
    do_reset();
    r0 = req_cnt;
    btn = 4'b1110;
    tick(6);
    chk("hold_first", pos_x, 5);
    tick(24);
    btn = 4'hF;
    tick(10);
    chk("hold_px", pos_x, 0);
    chk("hold_py", pos_y, 11);
    chk("hold_req", req_cnt - r0, 6);
    chk("hold_busy", busy, 0);

    // Pending buffer: U then D while busy, only D follows
    do_reset();
    r0 = req_cnt;
    btn = 4'b0111; tick(1);
    btn = 4'b1011; tick(1);
    btn = 4'b1101; tick(1);
    btn = 4'hF;    tick(12);
    chk("pend_px", pos_x, 7);
    chk("pend_py", pos_y, 12);
    chk("pend_face", facing, 2);
    chk("pend_req", req_cnt - r0, 2);

    // Lock while a move is in flight: it completes, nothing follows
    do_reset();
    r0 = req_cnt;
    btn = 4'b0111; tick(1);
    btn = 4'hF;    tick(1);
    lock = 1'b1;
    btn = 4'b1011; tick(1);
    btn = 4'b1101; tick(1);
    btn = 4'hF;    tick(12);
    chk("lock_px", pos_x, 7);
    chk("lock_py", pos_y, 11);
    chk("lock_req", req_cnt - r0, 1);
    chk("lock_busy", busy, 0);
    lock = 1'b0;

    // No response: timeout after 15 WAIT cycles
    do_reset();
    resp_en = 1'b0;
    r0 = req_cnt;
    btn = 4'b1011; tick(1);
    btn = 4'hF;    tick(16);
    chk("to_busy_last", busy, 1);
    tick(1);
    chk("to_busy_done", busy, 0);
    chk("to_py", pos_y, 11);
    chk("to_face", facing, 1);
    chk("to_req", req_cnt - r0, 1);

    // Reset asserted during WAIT
    btn = 4'b0111; tick(1);
    btn = 4'hF;    tick(4);
    chk("rw_busy", busy, 1);
    chk("rw_gx", ram.goto_pos_x, 7);
    rstn = 1'b0;
    fr_m = 1'b0;
    #1;
    chk_reset_state("rw");
    tick(1);
    rstn = 1'b1;
    stray = 1'b1;
    tick(2);
    stray = 1'b0;
    resp_en = 1'b1;
    tick(3);
    chk("stray_px", pos_x, 6);
    chk("stray_busy", busy, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
